// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam int         BCD_DIGITS = 6;
  localparam int         BCD_MAX    = 999999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble per-nibble correction: values of 5 or more get 3 added, no carry out.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] fixed
);

  always_comb begin
    fixed = nibble;
    if (nibble >= 4'd5) fixed = nibble + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter, one input bit per clock.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (4'hF) in the result.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 20,
  parameter int DIGITS    = BCD_DIGITS,
  parameter int MAX_VALUE = BCD_MAX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  // Handshake: start is sampled only in IDLE; busy is high in SHIFT and DONE;
  // done pulses for exactly one cycle while bcd_out/overflow hold the fresh result.
  state_e               state;
  state_e               state_nx;
  logic [BIN_WIDTH-1:0] binreg;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     corrected;
  logic [BCD_W-1:0]     shifted;
  logic [BCD_W-1:0]     result;
  logic [CNT_W-1:0]     cnt;
  logic                 over_range;
  logic                 last_shift;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .nibble (scratch[4*g +: 4]),
        .fixed  (corrected[4*g +: 4])
      );
    end
  endgenerate

  assign shifted    = {corrected[BCD_W-2:0], binreg[BIN_WIDTH-1]};
  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

`ifdef LEADING_ZERO_BLANK_EN
  logic leading;

  // Walk from the most significant digit; digit 0 always stays visible.
  always_comb begin
    result  = shifted;
    leading = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (leading && (shifted[4*d +: 4] == 4'h0)) begin
        result[4*d +: 4] = BCD_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign result = shifted;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      binreg     <= '0;
      scratch    <= '0;
      cnt        <= '0;
      over_range <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        binreg     <= bin_in;
        scratch    <= '0;
        cnt        <= CNT_W'(BIN_WIDTH);
        over_range <= (32'(bin_in) > 32'(MAX_VALUE));
      end else if (state == SHIFT) begin
        scratch <= shifted;
        binreg  <= {binreg[BIN_WIDTH-2:0], 1'b0};
        cnt     <= cnt - CNT_W'(1);
      end
      // Outputs move only here so the display never sees partial sums.
      if (last_shift) begin
        bcd_out  <= over_range ? {DIGITS{BCD_BLANK}} : result;
        overflow <= over_range;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus random values vs an arithmetic model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        overflow;

  int n_vec;
  int n_mis;

  logic [23:0] exp_q[$];
  logic        ovf_q[$];

  bin2bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: decimal digits by division, out-of-range shows all blanks
  function automatic logic [23:0] model_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    bit          lead;
    if (v > 999999) return 24'hFFFFFF;
    r = '0;
    x = v;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int d = 5; d >= 1; d--) begin
      if (lead && (r[4*d +: 4] == 4'h0)) r[4*d +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: compare the held result against the oldest expected entry
  task automatic score(input string tag);
    logic [23:0] eb;
    logic        eo;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    eb = exp_q.pop_front();
    eo = ovf_q.pop_front();
    check({tag, "_bcd"}, 32'(bcd_out), 32'(eb));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  task automatic push_exp(input logic [19:0] v);
    exp_q.push_back(model_bcd(32'(v)));
    ovf_q.push_back(32'(v) > 999999);
  endtask

  // waits at negedges until done; cyc counts edges since the accepting edge
  task automatic wait_done(input int cyc0, output int cyc, output int busy_lo);
    cyc = cyc0;
    busy_lo = 0;
    while (!done && cyc < 60) begin
      if (!busy) busy_lo++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_conv(input logic [19:0] v, input string tag);
    int cyc;
    int blo;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    push_exp(v);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 20'($urandom);
    wait_done(1, cyc, blo);
    check({tag, "_latency"}, 32'(cyc), 32'd21);
    check({tag, "_busy_gap"}, 32'(blo), 32'd0);
    score(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int blo;
    int t;
    int prev;
    int k;
    int dones;
    logic [19:0] rv;

    n_vec  = 0;
    n_mis  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    do_conv(20'd0, "zero");
    do_conv(20'd123456, "d123456");
    do_conv(20'd999999, "max");
    do_conv(20'd1000000, "over");
    do_conv(20'd1048575, "allones");

    // start during SHIFT is ignored
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd42;
    push_exp(20'd42);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, cyc, blo);
    check("ignore_latency", 32'(cyc), 32'd21);
    score("ignore");
    @(negedge clk);
    repeat (25) begin
      @(negedge clk);
      check("ignore_no_retrigger", 32'(busy), 32'd0);
    end

    // reset mid-conversion discards everything
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd555555;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bcd", 32'(bcd_out), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    do_conv(20'd65536, "after_rst");

    // start held high: back-to-back conversions
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd1;
    t = 0;
    prev = 0;
    k = 1;
    while (k <= 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (done) begin
        push_exp(20'(k));
        score("held");
        if (k > 1) check("held_sep", 32'(t - prev), 32'd22);
        prev = t;
        k++;
        bin_in = 20'(k);
        if (k > 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_count", 32'(k), 32'd4);
    @(negedge clk);

    // random values across the full input range, biased into range
    for (int i = 0; i < 30; i++) begin
      if (i % 4 == 3) rv = 20'($urandom_range(1000000, 1048575));
      else if (i % 4 == 2) rv = 20'($urandom_range(0, 99));
      else rv = 20'($urandom_range(0, 999999));
      do_conv(rv, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
